pixel_sink: RTL
===============

# pixel_sink

Consumer end of the drawing-engine pixel stream. It accepts the `x`/`y`/`valid` pixel strobes emitted by the shape drawers, which cannot be back-pressured. Pixels are clipped against the screen, buffered in a small FIFO, converted to linear framebuffer addresses and written through a ready/valid framebuffer write port. It also turns the drawer's `done` pulse into a single "all pixels committed" pulse, so the sequencer knows when the framebuffer is consistent.

## Interface
Parameters:
- `SCREEN_W`, 160: visible width in pixels.
- `SCREEN_H`, 120: visible height in pixels.
- `ADDR_W`, 15: framebuffer address width; must satisfy `SCREEN_W*SCREEN_H <= 2**ADDR_W`.
- `FIFO_DEPTH`, 8: pixel FIFO entries; power of two, at least 2.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `pix_x`, in, 8: pixel X coordinate.
- `pix_y`, in, 8: pixel Y coordinate.
- `pix_valid`, in, 1: pixel strobe; one pixel per high cycle; no back-pressure.
- `color`, in, 2: pixel colour, sampled with `pix_valid`.
- `src_done`, in, 1: one-cycle pulse; the source has emitted its last pixel.
- `clear`, in, 1: one-cycle pulse; clears `overflow` and `clip_cnt`.
- `fb_addr`, out, ADDR_W: write address, `y*SCREEN_W + x`.
- `fb_data`, out, 2: write colour.
- `fb_we`, out, 1: write valid; held with address and data stable until `fb_ready`.
- `fb_ready`, in, 1: framebuffer accepts the write in any cycle where `fb_we && fb_ready`.
- `busy`, out, 1: pixels in flight or a done is pending.
- `done`, out, 1: one-cycle pulse; every pixel before `src_done` has been written.
- `overflow`, out, 1: sticky; a pixel was dropped because the FIFO was full.
- `clip_cnt`, out, 8: count of clipped pixels; saturates at 255.

## Operation
- **Accept:** on a `pix_valid` cycle, a pixel is in range when `pix_x < SCREEN_W` and `pix_y < SCREEN_H`.
  - Out-of-range pixel: dropped, `clip_cnt` incremented.
  - In-range pixel with the FIFO not full, or a pop in the same cycle: pushed as {x, y, color}.
  - In-range pixel with the FIFO full and no pop: dropped, `overflow` set to 1.
- **Output register:** loaded from the FIFO head whenever it is empty, or when `fb_we && fb_ready`. On load, the address is computed as `y*SCREEN_W + x`, truncated to `ADDR_W`.
  - `fb_we` stays high while the register holds a pixel.
  - A fresh load in the same cycle as a handshake gives back-to-back writes at one per cycle.
- **Capacity before loss:** FIFO_DEPTH + 1 pixels (FIFO plus output register).
- **State machine:**
  - IDLE: waiting. `pix_valid` → RUN. `src_done` → FLUSH.
  - RUN: `src_done` → FLUSH. Pixels are still accepted.
  - FLUSH: pixels are still accepted. When the FIFO is empty and `fb_we` is 0, `done` pulses for one cycle and the state returns to IDLE.
  - `src_done` in FLUSH is absorbed; only one `done` is issued.
- **Simultaneous events:**
  - `src_done` and the last `pix_valid` in the same cycle: the pixel is included before `done`.
  - `clear` together with a clip or overflow event: `clear` wins; the counters end at 0.
- **Status outputs:**
  - `busy` = (state != IDLE) or FIFO non-empty or `fb_we`.
  - `clip_cnt` and `overflow` change only on events or on `clear`.
- **Reset:** `rst_n` low at a clock edge, including mid-stream or mid-handshake:
  - FIFO emptied, state IDLE.
  - `fb_we`, `done`, `busy`, `overflow` = 0.
  - `fb_addr`, `fb_data`, `clip_cnt` = 0.
  - Any pending write is abandoned without a handshake.

## Timing
- Pixel sampled at edge N, FIFO empty and output idle: `fb_we` is high after edge N+1. Latency is 2 cycles.
- Sustained throughput is 1 pixel per cycle with `fb_ready` tied high.
- `done` is asserted the cycle after the edge that completed the last handshake, provided the FIFO is empty.
- With nothing in flight, `done` follows `src_done` by 1 cycle.
- `fb_addr` and `fb_data` must not change while `fb_we && !fb_ready`.

## Configuration
- `PIXEL_SINK_CLIP_EN` defined: clipping as described; `clip_cnt` is live.
- Macro undefined:
  - No range check; every valid pixel is pushed.
  - Address is `y*SCREEN_W + x` truncated to `ADDR_W`, which may alias.
  - `clip_cnt` is tied to 0.

## Test plan
- **Single pixel, latency:** pixel (3,2), colour 2, `fb_ready` = 1 → 2 cycles later `fb_addr` = 323, `fb_data` = 2, `fb_we` high for 1 cycle.
- **Clip:** pixels (200,5) then (5,130) → no write, `clip_cnt` = 2. Then `clear` → `clip_cnt` = 0.
- **Back-pressure and overflow:** `fb_ready` = 0, 10 consecutive pixels → `overflow` = 1. Then `fb_ready` = 1 → exactly 9 writes, in order, with stable address/data while stalled.
- **Done ordering:** 3 pixels then `src_done`, `fb_ready` toggling 1010… → one `done` pulse, in the cycle after the third handshake; `busy` falls with it.
- **Streaming:** 32-pixel contiguous line at y = 119, `fb_ready` = 1 → 32 back-to-back writes, addresses 19040..19071.
- **Reset mid-stream:** `rst_n` low for 1 cycle with 4 pixels buffered → next cycle `fb_we` = 0, `busy` = 0, and no stale writes afterward.

Source files
------------

// File: rtl/pixel_sink.sv
// Pixel stream sink: clip, buffer and write drawer pixels to the framebuffer; optional clipping under PIXEL_SINK_CLIP_EN.
// Latency: pixel sampled at edge N shows as fb_we after edge N+1; one write per cycle sustained.
// Backpressure: the source cannot be stalled; fb_ready stalls the output register and FIFO, overflow drops are flagged.
module pixel_sink #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        pix_x,
  input  logic [7:0]        pix_y,
  input  logic              pix_valid,
  input  logic [1:0]        color,
  input  logic              src_done,
  input  logic              clear,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [1:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        clip_cnt
);

`ifdef PIXEL_SINK_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0] SW = 32'(SCREEN_W);
  localparam logic [31:0] SH = 32'(SCREEN_H);

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] color;
  } pix_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  pix_t              mem_q [FIFO_DEPTH];
  pix_t              mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [1:0]        fb_data_q, fb_data_d;
  logic              fb_we_q, fb_we_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        clip_cnt_q, clip_cnt_d;
  state_t            state_q, state_d;

  logic              in_range;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              clip_ev;
  logic              ovf_ev;
  pix_t              head;
  logic [31:0]       addr_full;

  // Accept/drop decisions, FIFO bookkeeping, output register load and status counters
  always_comb begin
    in_range   = ClipEn ? (({24'd0, pix_x} < SW) && ({24'd0, pix_y} < SH)) : 1'b1;
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    // The output register takes a new pixel when it is empty or its write completes this cycle
    pop        = !fifo_empty && (!fb_we_q || fb_ready);
    // A full FIFO still accepts a pixel when the head leaves in the same cycle
    push       = pix_valid && in_range && (!fifo_full || pop);
    clip_ev    = pix_valid && !in_range;
    ovf_ev     = pix_valid && in_range && fifo_full && !pop;
    head       = mem_q[rd_ptr_q];
    addr_full  = {24'd0, head.y} * SW + {24'd0, head.x};

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{x: pix_x, y: pix_y, color: color};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    fb_we_d   = fb_we_q;
    if (fb_we_q && fb_ready) begin
      fb_we_d = 1'b0;
    end
    if (pop) begin
      fb_addr_d = addr_full[ADDR_W-1:0];
      fb_data_d = head.color;
      fb_we_d   = 1'b1;
    end

    // clear takes priority over a same-cycle clip or overflow event
    overflow_d = overflow_q;
    clip_cnt_d = clip_cnt_q;
    if (clear) begin
      overflow_d = 1'b0;
      clip_cnt_d = 8'd0;
    end else begin
      if (ovf_ev) begin
        overflow_d = 1'b1;
      end
      if (clip_ev && (clip_cnt_q != 8'hFF)) begin
        clip_cnt_d = clip_cnt_q + 8'd1;
      end
    end
  end

  // Sequencing: one done pulse once everything before src_done has been written
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (src_done) begin
          state_d = ST_FLUSH;
        end else if (pix_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (src_done) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty && !fb_we_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers with synchronous reset; a pending write is abandoned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
      overflow_q <= 1'b0;
      clip_cnt_q <= 8'd0;
      state_q    <= ST_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
      overflow_q <= overflow_d;
      clip_cnt_q <= clip_cnt_d;
      state_q    <= state_d;
    end
  end

  // FIFO storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign fb_we    = fb_we_q;
  assign overflow = overflow_q;
  assign clip_cnt = clip_cnt_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty || fb_we_q;

endmodule
